// File: rtl/router_pkg.sv
// Shared definitions for the router packet transmitter: FSM states,
// header field positions and the header packing helper.
package router_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HEADER,
    ST_PAYLOAD,
    ST_PARITY,
    ST_GAP
  } tx_state_t;

  localparam logic [1:0] ADDR_ILLEGAL = 2'b11;
  localparam int MAX_PAYLOAD = 63;
  localparam int BUF_DEPTH   = MAX_PAYLOAD + 1;
  localparam int PTR_W       = 6;
  localparam int BYTE_W      = 8;

  localparam int HDR_ADDR_LO = 0;
  localparam int HDR_ADDR_HI = 1;
  localparam int HDR_LEN_LO  = 2;
  localparam int HDR_LEN_HI  = 7;

  function automatic logic [BYTE_W-1:0] make_header(input logic [1:0] addr,
                                                    input logic [PTR_W-1:0] len);
    logic [BYTE_W-1:0] h;
    h = '0;
    h[HDR_ADDR_HI:HDR_ADDR_LO] = addr;
    h[HDR_LEN_HI:HDR_LEN_LO]   = len;
    return h;
  endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Single-clock payload buffer: one write port, one registered read port.
// A read of the address being written returns the new byte (write-first).
import router_pkg::*;

module router_tx_buf #(
  parameter int DATA_W = BYTE_W,
  parameter int DEPTH  = BUF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
  end

endmodule

// File: rtl/router_pkt_tx.sv
// Host-side router packet transmitter: buffers a payload, then sends
// header, payload and parity beats under router busy flow control.
import router_pkg::*;

module router_pkt_tx #(
  parameter int IPG_CYCLES   = 2,
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic [1:0]        dest_addr,
  input  logic [PTR_W-1:0]  pl_len,
  input  logic [BYTE_W-1:0] pl_data,
  input  logic              pl_valid,
  output logic              pl_ready,
  input  logic              busy,
  input  logic              err_in,
  output logic              pkt_valid,
  output logic [BYTE_W-1:0] data_out,
  output logic              tx_active,
  output logic              done,
  output logic              reject,
  output logic              timeout,
  output logic              parity_err
);

  localparam int GCNT_W = (IPG_CYCLES > 2) ? $clog2(IPG_CYCLES) : 1;
  localparam int BCNT_W = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [GCNT_W-1:0] GCNT_LAST = GCNT_W'(IPG_CYCLES - 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST =
    (BUSY_TIMEOUT > 0) ? BCNT_W'(BUSY_TIMEOUT - 1) : '1;

  function automatic logic [BCNT_W-1:0] sat_inc(input logic [BCNT_W-1:0] v);
    return (v == '1) ? v : v + BCNT_W'(1);
  endfunction

  tx_state_t         state, state_nxt;
  logic [1:0]        addr_q, addr_nxt;
  logic [PTR_W-1:0]  len_q, len_nxt;
  logic [BYTE_W-1:0] acc, acc_nxt;
  logic [PTR_W-1:0]  wptr, wptr_nxt;
  logic [PTR_W-1:0]  rptr, rptr_nxt;
  logic [PTR_W-1:0]  fptr, fptr_nxt;
  logic [GCNT_W-1:0] gcnt, gcnt_nxt;
  logic [BCNT_W-1:0] bcnt, bcnt_nxt;
  logic              pkt_valid_nxt;
  logic [BYTE_W-1:0] data_out_nxt;
  logic              reject_nxt, timeout_nxt, parity_err_nxt;
  logic              buf_we, buf_re;
  logic [BYTE_W-1:0] buf_rdata;
  logic              in_tx;

  // fptr runs one byte ahead of the byte on data_out so buf_rdata is
  // already valid when the current beat is consumed.
  router_tx_buf u_buf (
    .clock (clock),
    .we    (buf_we),
    .waddr (wptr),
    .wdata (pl_data),
    .re    (buf_re),
    .raddr (fptr),
    .rdata (buf_rdata)
  );

  assign in_tx     = (state == ST_HEADER) || (state == ST_PAYLOAD) || (state == ST_PARITY);
  assign pl_ready  = (state == ST_LOAD);
  assign tx_active = (state != ST_IDLE);
  assign done      = (state == ST_GAP) && (gcnt == GCNT_LAST);

  always_comb begin
    state_nxt      = state;
    addr_nxt       = addr_q;
    len_nxt        = len_q;
    acc_nxt        = acc;
    wptr_nxt       = wptr;
    rptr_nxt       = rptr;
    fptr_nxt       = fptr;
    gcnt_nxt       = gcnt;
    pkt_valid_nxt  = pkt_valid;
    data_out_nxt   = data_out;
    reject_nxt     = 1'b0;
    timeout_nxt    = 1'b0;
    parity_err_nxt = parity_err;
    buf_we         = 1'b0;
    buf_re         = 1'b0;
    bcnt_nxt       = (in_tx && busy) ? sat_inc(bcnt) : '0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          if ((dest_addr != ADDR_ILLEGAL) && (pl_len != '0)) begin
            addr_nxt       = dest_addr;
            len_nxt        = pl_len;
            acc_nxt        = make_header(dest_addr, pl_len);
            wptr_nxt       = '0;
            rptr_nxt       = '0;
            fptr_nxt       = '0;
            parity_err_nxt = 1'b0;
            state_nxt      = ST_LOAD;
          end else begin
            reject_nxt = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (pl_valid) begin
          buf_we   = 1'b1;
          wptr_nxt = wptr + PTR_W'(1);
          acc_nxt  = acc ^ pl_data;
          if (wptr == len_q - PTR_W'(1)) begin
            state_nxt     = ST_HEADER;
            pkt_valid_nxt = 1'b1;
            data_out_nxt  = make_header(addr_q, len_q);
            buf_re        = 1'b1;
            fptr_nxt      = fptr + PTR_W'(1);
          end
        end
      end
      ST_HEADER: begin
        if (!busy) begin
          state_nxt    = ST_PAYLOAD;
          rptr_nxt     = '0;
          data_out_nxt = buf_rdata;
          if (fptr < len_q) begin
            buf_re   = 1'b1;
            fptr_nxt = fptr + PTR_W'(1);
          end
        end
      end
      ST_PAYLOAD: begin
        if (!busy) begin
          if (rptr == len_q - PTR_W'(1)) begin
            state_nxt     = ST_PARITY;
            pkt_valid_nxt = 1'b0;
            data_out_nxt  = acc;
          end else begin
            rptr_nxt     = rptr + PTR_W'(1);
            data_out_nxt = buf_rdata;
            if (fptr < len_q) begin
              buf_re   = 1'b1;
              fptr_nxt = fptr + PTR_W'(1);
            end
          end
        end
      end
      ST_PARITY: begin
        if (!busy) begin
          state_nxt     = ST_GAP;
          gcnt_nxt      = '0;
          pkt_valid_nxt = 1'b0;
          data_out_nxt  = '0;
        end
      end
      ST_GAP: begin
        if (err_in) parity_err_nxt = 1'b1;
        if (gcnt == GCNT_LAST) state_nxt = ST_IDLE;
        else                   gcnt_nxt  = gcnt + GCNT_W'(1);
      end
      default: state_nxt = ST_IDLE;
    endcase

    // A stalled router for too long abandons the packet without parity.
    if (in_tx && busy && (BUSY_TIMEOUT != 0) && (bcnt == BCNT_LAST)) begin
      state_nxt     = ST_IDLE;
      pkt_valid_nxt = 1'b0;
      data_out_nxt  = '0;
      timeout_nxt   = 1'b1;
      buf_re        = 1'b0;
      fptr_nxt      = fptr;
      rptr_nxt      = rptr;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      acc        <= '0;
      wptr       <= '0;
      rptr       <= '0;
      fptr       <= '0;
      gcnt       <= '0;
      bcnt       <= '0;
      pkt_valid  <= 1'b0;
      data_out   <= '0;
      reject     <= 1'b0;
      timeout    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      state      <= state_nxt;
      addr_q     <= addr_nxt;
      len_q      <= len_nxt;
      acc        <= acc_nxt;
      wptr       <= wptr_nxt;
      rptr       <= rptr_nxt;
      fptr       <= fptr_nxt;
      gcnt       <= gcnt_nxt;
      bcnt       <= bcnt_nxt;
      pkt_valid  <= pkt_valid_nxt;
      data_out   <= data_out_nxt;
      reject     <= reject_nxt;
      timeout    <= timeout_nxt;
      parity_err <= parity_err_nxt;
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for router_pkt_tx: start-decode table, packet table, random
// packets against a queue-based packet model, timeout and reset sequences.
module tb_router_pkt_tx;

  localparam int IPG = 2;
  localparam int BTO = 64;

  logic       clock = 1'b0;
  logic       resetn;
  logic       start;
  logic [1:0] dest_addr;
  logic [5:0] pl_len;
  logic [7:0] pl_data;
  logic       pl_valid;
  logic       pl_ready;
  logic       busy;
  logic       err_in;
  logic       pkt_valid;
  logic [7:0] data_out;
  logic       tx_active;
  logic       done;
  logic       reject;
  logic       timeout;
  logic       parity_err;

  int total = 0;
  int bad   = 0;
  logic [7:0] pay [63];

  router_pkt_tx #(.IPG_CYCLES(IPG), .BUSY_TIMEOUT(BTO)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .start      (start),
    .dest_addr  (dest_addr),
    .pl_len     (pl_len),
    .pl_data    (pl_data),
    .pl_valid   (pl_valid),
    .pl_ready   (pl_ready),
    .busy       (busy),
    .err_in     (err_in),
    .pkt_valid  (pkt_valid),
    .data_out   (data_out),
    .tx_active  (tx_active),
    .done       (done),
    .reject     (reject),
    .timeout    (timeout),
    .parity_err (parity_err)
  );

  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_pkt_valid"}, pkt_valid, 0);
    chk({nm, "_data_out"}, data_out, 0);
    chk({nm, "_pl_ready"}, pl_ready, 0);
    chk({nm, "_tx_active"}, tx_active, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_reject"}, reject, 0);
    chk({nm, "_timeout"}, timeout, 0);
    chk({nm, "_parity_err"}, parity_err, 0);
  endtask

  task automatic fill_pay(input int pmode);
    for (int i = 0; i < 63; i++) begin
      case (pmode)
        0:       pay[i] = 8'(8'h11 * (i + 1));
        1:       pay[i] = 8'(i);
        default: pay[i] = 8'($urandom_range(0, 255));
      endcase
    end
  endtask

  // Start a legal packet and stream its payload with pl_valid held high.
  task automatic load_pkt(input logic [1:0] a, input logic [5:0] n);
    start = 1'b1; dest_addr = a; pl_len = n;
    tick();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      pl_valid = 1'b1; pl_data = pay[i];
      tick();
    end
    pl_valid = 1'b0;
  endtask

  // Full packet: expected beats come from header={len,addr}, the payload,
  // and parity as XOR of header and every payload byte.
  task automatic run_pkt(input logic [1:0] a, input logic [5:0] n,
                         input int vmode, input int bmode, input bit errg);
    logic [7:0] exp_q [$];
    logic [7:0] hdr, par;
    int cnt, guard, k, hold;
    logic v, b;
    hdr = {n, a};
    par = hdr;
    exp_q.push_back(hdr);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(pay[i]);
      par ^= pay[i];
    end
    exp_q.push_back(par);

    start = 1'b1; dest_addr = a; pl_len = n;
    tick();
    start = 1'b0;
    chk("load_active", tx_active, 1);
    chk("load_perr_cleared", parity_err, 0);

    cnt = 0; guard = 0;
    while (cnt < n && guard < 500) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = guard[0];
        default: v = 1'($urandom_range(0, 1));
      endcase
      pl_valid = v; pl_data = pay[cnt];
      chk("load_ready", pl_ready, 1);
      chk("load_no_valid", pkt_valid, 0);
      tick();
      if (v) cnt++;
      guard++;
    end
    pl_valid = 1'b0;
    chk("load_budget", cnt, n);

    k = 0; guard = 0; hold = 0;
    while (k < exp_q.size() && guard < 400) begin
      case (bmode)
        1:       b = (k == 1) && (hold < 3);
        2:       b = ($urandom_range(0, 3) == 0);
        default: b = 1'b0;
      endcase
      if (b) hold++;
      busy = b;
      start = 1'b1; dest_addr = 2'd3; pl_len = 6'd0;
      chk("beat_data", data_out, exp_q[k]);
      chk("beat_valid", pkt_valid, 32'(k <= n));
      chk("beat_active", tx_active, 1);
      chk("beat_ready", pl_ready, 0);
      chk("beat_no_reject", reject, 0);
      tick();
      if (!b) k++;
      guard++;
    end
    busy = 1'b0; start = 1'b0;
    chk("tx_budget", k, exp_q.size());

    for (int g = 0; g < IPG; g++) begin
      chk("gap_valid", pkt_valid, 0);
      chk("gap_data", data_out, 0);
      chk("gap_done", done, 32'(g == IPG - 1));
      chk("gap_active", tx_active, 1);
      chk("gap_no_reject", reject, 0);
      err_in = errg && (g == IPG - 1);
      tick();
    end
    err_in = 1'b0;
    chk("end_idle", tx_active, 0);
    chk("end_done_low", done, 0);
    chk("end_parity_err", parity_err, 32'(errg));
  endtask

  typedef struct {
    logic [1:0] a;
    logic [5:0] n;
    logic       rej;
  } dec_t;

  typedef struct {
    logic [1:0] a;
    logic [5:0] n;
    int         pmode;
    int         vmode;
    int         bmode;
    bit         errg;
  } pkt_t;

  initial begin
    dec_t dec [8];
    pkt_t pkts [5];

    dec[0] = '{2'd3, 6'd5,  1'b1};
    dec[1] = '{2'd0, 6'd0,  1'b1};
    dec[2] = '{2'd3, 6'd0,  1'b1};
    dec[3] = '{2'd0, 6'd1,  1'b0};
    dec[4] = '{2'd2, 6'd63, 1'b0};
    dec[5] = '{2'd3, 6'd63, 1'b1};
    dec[6] = '{2'd1, 6'd17, 1'b0};
    dec[7] = '{2'd2, 6'd0,  1'b1};

    pkts[0] = '{2'd1, 6'd3,  0, 0, 0, 1'b0};
    pkts[1] = '{2'd1, 6'd3,  0, 0, 1, 1'b0};
    pkts[2] = '{2'd2, 6'd63, 1, 1, 0, 1'b0};
    pkts[3] = '{2'd0, 6'd1,  2, 0, 2, 1'b0};
    pkts[4] = '{2'd1, 6'd20, 2, 2, 2, 1'b1};

    resetn = 1'b0; start = 1'b0; dest_addr = '0; pl_len = '0;
    pl_data = '0; pl_valid = 1'b0; busy = 1'b0; err_in = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");
    resetn = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      start = 1'b1; dest_addr = dec[i].a; pl_len = dec[i].n;
      tick();
      start = 1'b0;
      chk("dec_reject", reject, 32'(dec[i].rej));
      chk("dec_active", tx_active, 32'(!dec[i].rej));
      chk("dec_ready", pl_ready, 32'(!dec[i].rej));
      tick();
      chk("dec_reject_pulse", reject, 0);
      chk("dec_active_hold", tx_active, 32'(!dec[i].rej));
      if (!dec[i].rej) begin
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk("dec_abort_idle", tx_active, 0);
      end
    end

    for (int i = 0; i < 5; i++) begin
      fill_pay(pkts[i].pmode);
      run_pkt(pkts[i].a, pkts[i].n, pkts[i].vmode, pkts[i].bmode, pkts[i].errg);
    end

    // parity_err survives a rejected start, clears on the next accepted one
    start = 1'b1; dest_addr = 2'd3; pl_len = 6'd4;
    tick();
    start = 1'b0;
    chk("sticky_reject", reject, 1);
    chk("sticky_perr", parity_err, 1);
    tick();

    for (int r = 0; r < 6; r++) begin
      fill_pay(2);
      run_pkt(2'($urandom_range(0, 2)), 6'($urandom_range(1, 63)),
              int'($urandom_range(0, 2)), 2, 1'($urandom_range(0, 1)));
    end

    // busy run of BTO-1 in HEADER, one free cycle, then BTO in PAYLOAD
    fill_pay(2);
    load_pkt(2'd2, 6'd5);
    busy = 1'b1;
    for (int i = 0; i < BTO - 1; i++) begin
      chk("to_hdr_valid", pkt_valid, 1);
      chk("to_hdr_data", data_out, {6'd5, 2'd2});
      chk("to_hdr_no_timeout", timeout, 0);
      tick();
    end
    busy = 1'b0;
    chk("to_hdr_still", data_out, {6'd5, 2'd2});
    tick();
    busy = 1'b1;
    for (int i = 0; i < BTO; i++) begin
      chk("to_pl_data", data_out, pay[0]);
      chk("to_pl_no_timeout", timeout, 0);
      chk("to_pl_active", tx_active, 1);
      tick();
    end
    busy = 1'b0;
    chk("to_pulse", timeout, 1);
    chk("to_valid_low", pkt_valid, 0);
    chk("to_data_zero", data_out, 0);
    chk("to_idle", tx_active, 0);
    chk("to_no_done", done, 0);
    tick();
    chk("to_pulse_end", timeout, 0);
    chk("to_no_done_after", done, 0);
    fill_pay(2);
    run_pkt(2'd0, 6'd7, 0, 0, 1'b0);

    // reset while a payload byte is on the bus
    fill_pay(2);
    load_pkt(2'd0, 6'd4);
    tick();
    chk("rst_pl0", data_out, pay[0]);
    tick();
    chk("rst_pl1", data_out, pay[1]);
    resetn = 1'b0;
    tick();
    chk_all_zero("midreset");
    resetn = 1'b1;
    tick();
    chk("rst_stays_idle", tx_active, 0);
    fill_pay(0);
    run_pkt(2'd1, 6'd3, 0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
